// File: rtl/symbol_decoder.sv
// rtl/symbol_decoder.sv - 10-bit symbol to byte decoder with word-lock FSM and error counter
//
// Purpose : inverts the link encoder's 4b/6b code tables, flags illegal codes,
//           tracks word lock (HUNT/LOCKED) and counts code errors while locked.
// Ports   : clk, reset (async, active-low)
//           din[9:0], din_valid   - symbol in (din[9:6] 4b code, din[5:0] 6b code)
//           dout[7:0], dout_valid - decoded byte, one-cycle qualifier
//           code_err              - symbol held an illegal 4b or 6b code
//           locked                - FSM is LOCKED
//           err_cnt, err_clr      - saturating error count and its synchronous clear
// Option  : DEC_DATA_GATE_EN - forward only clean bytes decoded while LOCKED.
module symbol_decoder #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           din,
  input  logic                 din_valid,
  output logic [7:0]           dout,
  output logic                 dout_valid,
  output logic                 code_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [3:0]           LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]           UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  logic [0:0] state, state_nxt;
  logic [3:0] good_cnt, good_nxt;
  logic [3:0] bad_cnt, bad_nxt;
  logic       err_inc;

  logic [2:0] dec4;
  logic       ok4;
  logic [4:0] dec6;
  logic       ok6;
  logic       illegal;

  always_comb begin
    ok4 = 1'b1;
    case (din[9:6])
      4'b0100: dec4 = 3'd0;
      4'b1001: dec4 = 3'd1;
      4'b0101: dec4 = 3'd2;
      4'b0011: dec4 = 3'd3;
      4'b0010: dec4 = 3'd4;
      4'b1010: dec4 = 3'd5;
      4'b0110: dec4 = 3'd6;
      4'b0001: dec4 = 3'd7;
      default: begin dec4 = 3'd0; ok4 = 1'b0; end
    endcase
  end

  always_comb begin
    ok6 = 1'b1;
    case (din[5:0])
      6'b011000: dec6 = 5'd0;
      6'b011101: dec6 = 5'd1;
      6'b010010: dec6 = 5'd2;
      6'b110001: dec6 = 5'd3;
      6'b110101: dec6 = 5'd4;
      6'b101001: dec6 = 5'd5;
      6'b011001: dec6 = 5'd6;
      6'b111000: dec6 = 5'd7;
      6'b111001: dec6 = 5'd8;
      6'b100101: dec6 = 5'd9;
      6'b010101: dec6 = 5'd10;
      6'b110100: dec6 = 5'd11;
      6'b001101: dec6 = 5'd12;
      6'b101100: dec6 = 5'd13;
      6'b011100: dec6 = 5'd14;
      6'b010111: dec6 = 5'd15;
      6'b011011: dec6 = 5'd16;
      6'b100011: dec6 = 5'd17;
      6'b010011: dec6 = 5'd18;
      6'b110010: dec6 = 5'd19;
      6'b001011: dec6 = 5'd20;
      6'b101010: dec6 = 5'd21;
      6'b011010: dec6 = 5'd22;
      6'b111010: dec6 = 5'd23;
      6'b110011: dec6 = 5'd24;
      6'b100110: dec6 = 5'd25;
      6'b010110: dec6 = 5'd26;
      6'b110110: dec6 = 5'd27;
      6'b001110: dec6 = 5'd28;
      6'b101110: dec6 = 5'd29;
      6'b011110: dec6 = 5'd30;
      6'b101011: dec6 = 5'd31;
      default: begin dec6 = 5'd0; ok6 = 1'b0; end
    endcase
  end

  assign illegal = !(ok4 && ok6);

  // Lock FSM; everything here is qualified by din_valid so idle cycles leave it untouched.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    err_inc   = 1'b0;
    if (din_valid) begin
      if (state == ST_HUNT) begin
        if (illegal) begin
          good_nxt = 4'd0;
        end else if (good_cnt + 4'd1 == LOCK_N) begin
          state_nxt = ST_LOCKED;
          good_nxt  = good_cnt + 4'd1;
          bad_nxt   = 4'd0;
        end else begin
          good_nxt = good_cnt + 4'd1;
        end
      end else begin
        if (illegal) begin
          err_inc = 1'b1;
          if (bad_cnt + 4'd1 == UNLOCK_N) begin
            state_nxt = ST_HUNT;
            bad_nxt   = bad_cnt + 4'd1;
            good_nxt  = 4'd0;
          end else begin
            bad_nxt = bad_cnt + 4'd1;
          end
        end else begin
          bad_nxt = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_HUNT;
      good_cnt   <= 4'd0;
      bad_cnt    <= 4'd0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      code_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
      locked   <= (state_nxt == ST_LOCKED);
      if (din_valid) begin
        dout <= {dec4, dec6};
      end
`ifdef DEC_DATA_GATE_EN
      // code_err becomes a pulse because dout_valid no longer qualifies it.
      dout_valid <= din_valid && (state_nxt == ST_LOCKED) && !illegal;
      code_err   <= din_valid && illegal;
`else
      dout_valid <= din_valid;
      if (din_valid) begin
        code_err <= illegal;
      end
`endif
    end
  end

  // A clear coinciding with a counted error leaves that error counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= err_inc ? ERR_ONE : '0;
    end else if (err_inc && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_symbol_decoder.sv
// tb/tb_symbol_decoder.sv - scoreboard testbench for symbol_decoder
module tb_symbol_decoder;

  logic        clk;
  logic        reset;
  logic [9:0]  din;
  logic        din_valid;
  logic        err_clr;
  logic        err_clr_s;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        code_err;
  logic        locked;
  logic [15:0] err_cnt;
  logic [7:0]  dout_s;
  logic        dout_valid_s;
  logic        code_err_s;
  logic        locked_s;
  logic [1:0]  err_cnt_s;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    logic       l;
  } exp_t;

  exp_t sb_q[$];

  symbol_decoder #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .code_err(code_err),
    .locked(locked), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  symbol_decoder #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout_s), .dout_valid(dout_valid_s), .code_err(code_err_s),
    .locked(locked_s), .err_cnt(err_cnt_s), .err_clr(err_clr_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dout_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && dout_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_dout_valid", {24'h0, dout}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("dout", {24'h0, dout}, {24'h0, e.d});
`ifndef DEC_DATA_GATE_EN
        chk("code_err", {31'h0, code_err}, {31'h0, e.e});
`endif
        chk("locked", {31'h0, locked}, {31'h0, e.l});
      end
    end
  end

  // Drive one symbol; expected values are hand-computed per call.
  task automatic send(input logic [9:0] d, input logic [7:0] ed, input logic ee, input logic el);
    exp_t e;
    e.d = ed; e.e = ee; e.l = el;
`ifdef DEC_DATA_GATE_EN
    if (el && !ee) sb_q.push_back(e);
`else
    sb_q.push_back(e);
`endif
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    err_clr_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b0;
    din       = 10'h000;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    err_clr_s = 1'b0;
    idle(2);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_code_err", {31'h0, code_err}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    reset = 1'b1;
    idle(1);

    // Single symbol, then an illegal one to restart the hunt.
    send(10'h118, 8'h00, 1'b0, 1'b0);
    send(10'h000, 8'h00, 1'b1, 1'b0);
    chk("hunt_err_not_counted", {16'h0, err_cnt}, 32'h0);

    // Back-to-back lock sequence.
    send(10'h118, 8'h00, 1'b0, 1'b0);
    send(10'h06B, 8'hFF, 1'b0, 1'b0);
    send(10'h2A9, 8'hA5, 1'b0, 1'b0);
    send(10'h118, 8'h00, 1'b0, 1'b1);

    // Errors while locked, below the unlock threshold.
    send(10'h000, 8'h00, 1'b1, 1'b1);
    send(10'h06B, 8'hFF, 1'b0, 1'b1);
    send(10'h000, 8'h00, 1'b1, 1'b1);
    send(10'h000, 8'h00, 1'b1, 1'b1);
    chk("err_cnt_3", {16'h0, err_cnt}, 32'd3);
    chk("still_locked", {31'h0, locked}, 32'd1);
    send(10'h2A9, 8'hA5, 1'b0, 1'b1);
    send(10'h000, 8'h00, 1'b1, 1'b1);
    send(10'h000, 8'h00, 1'b1, 1'b1);
    send(10'h000, 8'h00, 1'b1, 1'b0);
    chk("err_cnt_6", {16'h0, err_cnt}, 32'd6);
    chk("unlocked", {31'h0, locked}, 32'd0);
    chk("small_sat_early", {30'h0, err_cnt_s}, 32'd3);

    // Half-illegal symbols in HUNT: legal half still decodes, not counted.
    send(10'h27F, 8'h20, 1'b1, 1'b0);
    send(10'h3D2, 8'h02, 1'b1, 1'b0);
    chk("hunt_err_hold", {16'h0, err_cnt}, 32'd6);

    // Gapped lock sequence with held dout.
    send(10'h24E, 8'h3C, 1'b0, 1'b0);
    idle(1);
    chk("gap_hold_3c", {24'h0, dout}, 32'h3C);
    chk("gap_no_valid", {31'h0, dout_valid}, 32'd0);
    idle(2);
    send(10'h1B1, 8'hC3, 1'b0, 1'b0);
    idle(3);
    chk("gap_hold_c3", {24'h0, dout}, 32'hC3);
    send(10'h118, 8'h00, 1'b0, 1'b0);
    idle(3);
    send(10'h06B, 8'hFF, 1'b0, 1'b1);
    idle(3);
    chk("gap_locked", {31'h0, locked}, 32'd1);

    // Saturation on the 2-bit counter.
    err_clr_s = 1'b1;
    idle(1);
    err_clr_s = 1'b0;
    chk("small_clr_alone", {30'h0, err_cnt_s}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(10'h000, 8'h00, 1'b1, 1'b1);
      send(10'h118, 8'h00, 1'b0, 1'b1);
    end
    chk("small_sat", {30'h0, err_cnt_s}, 32'd3);
    chk("main_err_11", {16'h0, err_cnt}, 32'd11);
    err_clr   = 1'b1;
    err_clr_s = 1'b1;
    send(10'h000, 8'h00, 1'b1, 1'b1);
    chk("small_clr_with_err", {30'h0, err_cnt_s}, 32'd1);
    chk("main_clr_with_err", {16'h0, err_cnt}, 32'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("main_clr_alone", {16'h0, err_cnt}, 32'd0);

    // Reset mid-stream while locked; the in-flight symbol is dropped.
    send(10'h2A9, 8'hA5, 1'b0, 1'b1);
    idle(1);
    chk("pre_rst_locked", {31'h0, locked}, 32'd1);
    din       = 10'h06B;
    din_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_dout", {24'h0, dout}, 32'h0);
    chk("mid_rst_locked", {31'h0, locked}, 32'h0);
    chk("mid_rst_code_err", {31'h0, code_err}, 32'h0);
    chk("mid_rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("mid_rst_no_valid", {31'h0, dout_valid}, 32'h0);
    reset = 1'b1;
    idle(1);

    // Relock after reset.
    send(10'h118, 8'h00, 1'b0, 1'b0);
    send(10'h06B, 8'hFF, 1'b0, 1'b0);
    send(10'h2A9, 8'hA5, 1'b0, 1'b0);
    send(10'h118, 8'h00, 1'b0, 1'b1);
    idle(4);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
